// File: rtl/reg_file_sched.sv
// reg_file_sched: single-issue scheduler in front of a register file that also
// holds a return-address stack. Each cycle at most one of these operations is
// issued: a register writeback (from the ALU or the load unit), a stack push
// (call), or a stack pop (ret).
//
// Handshake: a source holds its *_req (and payload) high until it sees its
// grant. The grant pulse lasts one cycle and the transaction is then complete.
// At the edge ending the grant cycle, the source may drop req or present a new
// transaction.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   a_req/a_ws/a_wd       ALU writeback request, register select, data
//   a_gnt                 ALU request granted (one-cycle pulse)
//   b_req/b_ws/b_wd       load-unit writeback request, register select, data
//   b_gnt                 load request granted (one-cycle pulse)
//   call_req/call_pc      push-return-address request and address
//   ret_req               pop-return-address request
//   stk_gnt               call or ret consumed this cycle
//   regwrite/ws/wd        register file write strobe, select, data
//   push/pop/stack_pc     stack strobes and push data
//   depth                 current stack occupancy
//   ovf/udf               sticky overflow / underflow flags
// All outputs are registered: requests sampled at edge N appear at N+1.
module reg_file_sched #(
    parameter int STACK_DEPTH = 8,
    parameter int DEPTH_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_req,
    input  logic [2:0]         a_ws,
    input  logic [31:0]        a_wd,
    output logic               a_gnt,
    input  logic               b_req,
    input  logic [2:0]         b_ws,
    input  logic [31:0]        b_wd,
    output logic               b_gnt,
    input  logic               call_req,
    input  logic [7:0]         call_pc,
    input  logic               ret_req,
    output logic               stk_gnt,
    output logic               regwrite,
    output logic [2:0]         ws,
    output logic [31:0]        wd,
    output logic               push,
    output logic               pop,
    output logic [7:0]         stack_pc,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf,
    output logic               udf
);

    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);

    logic               a_gnt_q, a_gnt_d;
    logic               b_gnt_q, b_gnt_d;
    logic               stk_gnt_q, stk_gnt_d;
    logic               regwrite_q, regwrite_d;
    logic               push_q, push_d;
    logic               pop_q, pop_d;
    logic [2:0]         ws_q, ws_d;
    logic [31:0]        wd_q, wd_d;
    logic [7:0]         stack_pc_q, stack_pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    // Round-robin pointer: 1 means b was served last, so a wins the next tie.
    logic               last_b_q, last_b_d;
    // stk_gnt is shared, so remember which stack requester it served.
    logic               call_gnt_q, call_gnt_d;
    logic               ret_gnt_q, ret_gnt_d;

    logic a_el, b_el, call_el, ret_el;

    always_comb begin
        // A requester granted in the current cycle sits out the next edge.
        a_el    = a_req    & ~a_gnt_q;
        b_el    = b_req    & ~b_gnt_q;
        call_el = call_req & ~call_gnt_q;
        ret_el  = ret_req  & ~ret_gnt_q;

        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        stk_gnt_d  = 1'b0;
        regwrite_d = 1'b0;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        call_gnt_d = 1'b0;
        ret_gnt_d  = 1'b0;
        ws_d       = ws_q;
        wd_d       = wd_q;
        stack_pc_d = stack_pc_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        last_b_d   = last_b_q;

        if (call_el) begin
            stk_gnt_d  = 1'b1;
            call_gnt_d = 1'b1;
            if (depth_q < FULL) begin
                push_d     = 1'b1;
                stack_pc_d = call_pc;
                depth_d    = depth_q + ONE;
            end else begin
                // Full stack: request is consumed but dropped.
                ovf_d = 1'b1;
            end
        end else if (ret_el) begin
            stk_gnt_d = 1'b1;
            ret_gnt_d = 1'b1;
            if (depth_q != '0) begin
                pop_d   = 1'b1;
                depth_d = depth_q - ONE;
            end else begin
                udf_d = 1'b1;
            end
        end else if (a_el && (!b_el || last_b_q)) begin
            a_gnt_d    = 1'b1;
            regwrite_d = 1'b1;
            ws_d       = a_ws;
            wd_d       = a_wd;
            last_b_d   = 1'b0;
        end else if (b_el) begin
            b_gnt_d    = 1'b1;
            regwrite_d = 1'b1;
            ws_d       = b_ws;
            wd_d       = b_wd;
            last_b_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            stk_gnt_q  <= 1'b0;
            regwrite_q <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            ws_q       <= '0;
            wd_q       <= '0;
            stack_pc_q <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            last_b_q   <= 1'b1;
            call_gnt_q <= 1'b0;
            ret_gnt_q  <= 1'b0;
        end else begin
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            stk_gnt_q  <= stk_gnt_d;
            regwrite_q <= regwrite_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            ws_q       <= ws_d;
            wd_q       <= wd_d;
            stack_pc_q <= stack_pc_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            last_b_q   <= last_b_d;
            call_gnt_q <= call_gnt_d;
            ret_gnt_q  <= ret_gnt_d;
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign stk_gnt  = stk_gnt_q;
    assign regwrite = regwrite_q;
    assign push     = push_q;
    assign pop      = pop_q;
    assign ws       = ws_q;
    assign wd       = wd_q;
    assign stack_pc = stack_pc_q;
    assign depth    = depth_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_reg_file_sched.sv
// Bench for reg_file_sched: directed scenarios followed by random traffic.
// A reference model in tick() predicts the full output vector of the cycle
// after each edge; a monitor on the falling edge pops and compares.
module tb_reg_file_sched;

    localparam int SD = 8;
    localparam int DW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          a_req, b_req, call_req, ret_req;
    logic [2:0]    a_ws, b_ws;
    logic [31:0]   a_wd, b_wd;
    logic [7:0]    call_pc;
    logic          a_gnt, b_gnt, stk_gnt, regwrite, push, pop, ovf, udf;
    logic [2:0]    ws;
    logic [31:0]   wd;
    logic [7:0]    stack_pc;
    logic [DW-1:0] depth;

    reg_file_sched #(.STACK_DEPTH(SD), .DEPTH_W(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_ws(a_ws), .a_wd(a_wd), .a_gnt(a_gnt),
        .b_req(b_req), .b_ws(b_ws), .b_wd(b_wd), .b_gnt(b_gnt),
        .call_req(call_req), .call_pc(call_pc), .ret_req(ret_req),
        .stk_gnt(stk_gnt), .regwrite(regwrite), .ws(ws), .wd(wd),
        .push(push), .pop(pop), .stack_pc(stack_pc), .depth(depth),
        .ovf(ovf), .udf(udf)
    );

    // ---------------- scoreboard state ----------------
    // Vector: {a_gnt,b_gnt,stk_gnt,regwrite,push,pop,ws,wd,stack_pc,depth,ovf,udf}
    logic [54:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stack as a queue, sticky flags, who was served last.
    logic [7:0]  m_stack[$];
    bit          m_ovf, m_udf;
    bit          m_prefer_a;          // next a/b tie goes to a
    bit          g_a, g_b, g_c, g_r;  // served in the cycle now being predicted
    logic [2:0]  m_ws;
    logic [31:0] m_wd;
    logic [7:0]  m_pc;

    // Predict the outputs produced by the coming edge, then advance one cycle.
    task automatic tick();
        bit ga = 0, gb = 0, gs = 0, rw = 0, pu = 0, po = 0, gc = 0, gr = 0;
        if (reset) begin
            m_stack.delete();
            m_ovf = 0; m_udf = 0; m_prefer_a = 1;
            m_ws = '0; m_wd = '0; m_pc = '0;
        end else if (call_req && !g_c) begin
            gs = 1; gc = 1;
            if (m_stack.size() < SD) begin
                pu = 1; m_pc = call_pc; m_stack.push_back(call_pc);
            end else m_ovf = 1;
        end else if (ret_req && !g_r) begin
            gs = 1; gr = 1;
            if (m_stack.size() > 0) begin
                po = 1; void'(m_stack.pop_back());
            end else m_udf = 1;
        end else begin
            bit wa, wb;
            wa = a_req && !g_a;
            wb = b_req && !g_b;
            if (wa && wb) begin
                if (m_prefer_a) wb = 0; else wa = 0;
            end
            if (wa) begin ga = 1; rw = 1; m_ws = a_ws; m_wd = a_wd; m_prefer_a = 0; end
            if (wb) begin gb = 1; rw = 1; m_ws = b_ws; m_wd = b_wd; m_prefer_a = 1; end
        end
        g_a = ga; g_b = gb; g_c = gc; g_r = gr;
        exp_q.push_back({ga, gb, gs, rw, pu, po, m_ws, m_wd, m_pc,
                         DW'(m_stack.size()), m_ovf, m_udf});
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver helpers ----------------
    task automatic idle();
        a_req = 0; b_req = 0; call_req = 0; ret_req = 0; reset = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    task automatic call_once(input logic [7:0] pc);
        idle(); call_req = 1; call_pc = pc; tick(); idle(); tick();
    endtask

    task automatic ret_once();
        idle(); ret_req = 1; tick(); idle(); tick();
    endtask

    // ---------------- monitor ----------------
    bit stop_mon = 0;
    initial begin
        while (!stop_mon) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [54:0] e, act;
                e   = exp_q.pop_front();
                act = {a_gnt, b_gnt, stk_gnt, regwrite, push, pop, ws, wd,
                       stack_pc, depth, ovf, udf};
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: actual gnt(a,b,s)=%b%b%b rw/push/pop=%b%b%b ws=%0d wd=%h pc=%h depth=%0d ovf=%b udf=%b | required gnt=%b%b%b rw/push/pop=%b%b%b ws=%0d wd=%h pc=%h depth=%0d ovf=%b udf=%b",
                             $time, act[54], act[53], act[52], act[51], act[50], act[49],
                             act[48:46], act[45:14], act[13:6], act[5:2], act[1], act[0],
                             e[54], e[53], e[52], e[51], e[50], e[49],
                             e[48:46], e[45:14], e[13:6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit a_on, b_on, c_on, r_on;
        int pcall;
        idle();
        a_ws = 0; a_wd = 0; b_ws = 0; b_wd = 0; call_pc = 0;
        g_a = 0; g_b = 0; g_c = 0; g_r = 0;

        // Reset state, then a/b held continuously: grants alternate a,b.
        do_reset(); do_reset();
        a_req = 1; a_ws = 3'd2; a_wd = 32'd10;
        b_req = 1; b_ws = 3'd3; b_wd = 32'd20;
        repeat (6) tick();
        idle(); tick();

        // Call concurrent with a writeback: push first, a later.
        do_reset();
        call_req = 1; call_pc = 8'd35; a_req = 1; a_ws = 3'd5; a_wd = 32'h55;
        tick();
        call_req = 0; tick(); tick();
        idle(); tick();

        // Fill, overflow, then ret keeps ovf.
        do_reset();
        for (int i = 0; i < 9; i++) call_once(8'(8'h40 + i));
        ret_once();

        // Underflow at depth 0.
        do_reset();
        ret_once();

        // Call and ret together at depth 1.
        do_reset();
        call_once(8'd7);
        call_req = 1; call_pc = 8'd9; ret_req = 1; tick();
        call_req = 0; tick();
        idle(); tick(); tick();

        // Reset while a grant is due, with depth 3 and ovf set.
        do_reset();
        for (int i = 0; i < 9; i++) call_once(8'(i));
        for (int i = 0; i < 5; i++) ret_once();
        a_req = 1; a_ws = 3'd1; a_wd = 32'hdead; reset = 1; tick();
        idle(); tick(); tick();

        // Random traffic: sources hold payload until granted.
        do_reset();
        a_on = 0; b_on = 0; c_on = 0; r_on = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            pcall = ((cyc / 250) % 2 == 0) ? 6 : 1;
            if (a_on && g_a) a_on = ($urandom_range(0, 1) == 1);
            else if (!a_on) a_on = ($urandom_range(0, 2) == 0);
            if (a_on && (g_a || !a_req)) begin
                a_ws = 3'($urandom_range(0, 7)); a_wd = $urandom;
            end
            if (b_on && g_b) b_on = ($urandom_range(0, 1) == 1);
            else if (!b_on) b_on = ($urandom_range(0, 2) == 0);
            if (b_on && (g_b || !b_req)) begin
                b_ws = 3'($urandom_range(0, 7)); b_wd = $urandom;
            end
            if (c_on && g_c) c_on = 0;
            else if (!c_on) c_on = ($urandom_range(0, 9) < pcall);
            if (c_on && !call_req) call_pc = 8'($urandom);
            if (r_on && g_r) r_on = 0;
            else if (!r_on) r_on = ($urandom_range(0, 9) < 7 - pcall);
            a_req = a_on; b_req = b_on; call_req = c_on; ret_req = r_on;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        idle(); tick();

        @(negedge clk);
        #1;
        stop_mon = 1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
